// File: rtl/sd_spi_pkg.sv
// Shared constants for the SPI-mode SD host engine: FSM encodings, CRC7 polynomial, tokens.
// Optional internal CRC7 generation is enabled with `define SD_SPI_CRC7_EN.
package sd_spi_pkg;

   localparam logic [1:0] ENG_IDLE = 2'd0;
   localparam logic [1:0] ENG_LO   = 2'd1;
   localparam logic [1:0] ENG_HI   = 2'd2;
   localparam logic [1:0] ENG_DONE = 2'd3;

   localparam logic [1:0] SEQ_IDLE = 2'd0;
   localparam logic [1:0] SEQ_SEND = 2'd1;
   localparam logic [1:0] SEQ_POLL = 2'd2;
   localparam logic [1:0] SEQ_FIN  = 2'd3;

   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam logic [7:0] FILL_BYTE       = 8'hFF;
   localparam logic [7:0] TOKEN_START     = 8'hFE;
   localparam logic [7:0] TOKEN_MULTI_WR  = 8'hFC;
   localparam logic [7:0] TOKEN_STOP_TRAN = 8'hFD;

   localparam int unsigned NCR_MAX_DEF = 8;
   localparam int unsigned CMD_BYTES   = 6;

   // One serial CRC7 step (x^7 + x^3 + 1), MSB-first data.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = crc[6] ^ bit_in;
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_spi_shift.sv
// SPI mode-0 byte engine: sck divider, LO/HI/DONE sequencing, MSB-first shift registers.
// With SD_SPI_CRC7_EN it also exposes a per-bit strobe for serial CRC generation.
module sd_spi_shift
   import sd_spi_pkg::*;
#(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk_spi,
   input  logic             reset,
   input  logic [DIV_W-1:0] div,
   input  logic             start,
   input  logic             cs,
   input  logic [7:0]       data,
   output logic             idle_c,
`ifdef SD_SPI_CRC7_EN
   output logic             bit_tick_c,
`endif
   output logic             rx_valid,
   output logic [7:0]       rx_data,
   output logic             ss,
   output logic             sck,
   output logic             mosi,
   input  logic             miso
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [DIV_W-1:0] hlim;
   logic [DIV_W-1:0] hcnt;
   logic [2:0]       bitn;
   logic [7:0]       tx_sh;
   logic [7:0]       rx_sh;
   logic             half_end;

   assign half_end = (hcnt == hlim);

`ifdef SD_SPI_CRC7_EN
   // Fires once per bit while that bit is on mosi.
   assign bit_tick_c = (state == ENG_LO) && half_end;
`endif

   always_ff @(posedge clk_spi) begin
      if (reset) state <= ENG_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      idle_c    = 1'b0;
      case (state)
         ENG_IDLE: begin
            idle_c = 1'b1;
            if (start) state_nxt = ENG_LO;
         end
         ENG_LO:   if (half_end) state_nxt = ENG_HI;
         ENG_HI:   if (half_end) state_nxt = (bitn == 3'd7) ? ENG_DONE : ENG_LO;
         ENG_DONE: state_nxt = ENG_IDLE;
         default:  state_nxt = ENG_IDLE;
      endcase
   end

   // Half-period limit is max(div,1); counting 0..hlim gives max(div,1)+1 cycles.
   always_ff @(posedge clk_spi) begin
      if (reset) begin
         hlim     <= '0;
         hcnt     <= '0;
         bitn     <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         ss       <= 1'b1;
         sck      <= 1'b0;
         mosi     <= 1'b1;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            ENG_IDLE: begin
               if (start) begin
                  hlim  <= (div == '0) ? DIV_W'(1) : div;
                  hcnt  <= '0;
                  bitn  <= '0;
                  tx_sh <= {data[6:0], 1'b0};
                  ss    <= ~cs;
                  mosi  <= data[7];
                  sck   <= 1'b0;
               end
            end
            ENG_LO: begin
               if (half_end) begin
                  hcnt <= '0;
                  sck  <= 1'b1;
               end else begin
                  hcnt <= hcnt + DIV_W'(1);
               end
            end
            ENG_HI: begin
               if (half_end) begin
                  hcnt  <= '0;
                  sck   <= 1'b0;
                  rx_sh <= {rx_sh[6:0], miso};
                  if (bitn == 3'd7) begin
                     mosi <= 1'b1;
                  end else begin
                     mosi  <= tx_sh[7];
                     tx_sh <= {tx_sh[6:0], 1'b0};
                     bitn  <= bitn + 3'd1;
                  end
               end else begin
                  hcnt <= hcnt + DIV_W'(1);
               end
            end
            ENG_DONE: begin
               rx_valid <= 1'b1;
               rx_data  <= rx_sh;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sd_spi_master.sv
// SPI-mode SD host: raw byte port plus a 6-byte command sequencer with R1 polling.
// `define SD_SPI_CRC7_EN to generate the command CRC7 internally (cmd_crc then ignored).
module sd_spi_master
   import sd_spi_pkg::*;
#(
   parameter int unsigned DIV_W   = 8,
   parameter int unsigned NCR_MAX = NCR_MAX_DEF
) (
   input  logic             clk_spi,
   input  logic             reset,
   input  logic [DIV_W-1:0] div,
   input  logic             cs_req,
   input  logic             tx_valid,
   input  logic [7:0]       tx_data,
   output logic             tx_ready,
   output logic             rx_valid,
   output logic [7:0]       rx_data,
   input  logic             cmd_start,
   input  logic [5:0]       cmd_index,
   input  logic [31:0]      cmd_arg,
   input  logic [6:0]       cmd_crc,
   output logic             cmd_done,
   output logic [7:0]       cmd_r1,
   output logic             cmd_timeout,
   output logic             busy,
   output logic             ss,
   output logic             sck,
   output logic             mosi,
   input  logic             miso
);

   localparam int unsigned PW = $clog2(NCR_MAX + 1);

   logic [1:0]    seq_state;
   logic [1:0]    seq_nxt;
   logic [2:0]    byte_idx;
   logic [PW-1:0] poll_cnt;
   logic [5:0]    lat_idx;
   logic [31:0]   lat_arg;
   logic [6:0]    crc_byte;
   logic [7:0]    cmd_byte;

   logic          eng_start;
   logic          eng_cs;
   logic [7:0]    eng_data;
   logic          eng_idle;
   logic          r1_hit;

`ifdef SD_SPI_CRC7_EN
   logic          bit_tick;
   logic [6:0]    crc_acc;
   logic          unused_cmd_crc;

   assign unused_cmd_crc = ^cmd_crc;
   assign crc_byte       = crc_acc;
`else
   logic [6:0]    lat_crc;

   assign crc_byte = lat_crc;
`endif

   assign busy     = ~eng_idle | (seq_state != SEQ_IDLE);
   assign tx_ready = eng_idle & (seq_state == SEQ_IDLE) & ~cmd_start;
   assign r1_hit   = rx_valid & ~rx_data[7];

   always_comb begin
      cmd_byte = FILL_BYTE;
      case (byte_idx)
         3'd0:    cmd_byte = {2'b01, lat_idx};
         3'd1:    cmd_byte = lat_arg[31:24];
         3'd2:    cmd_byte = lat_arg[23:16];
         3'd3:    cmd_byte = lat_arg[15:8];
         3'd4:    cmd_byte = lat_arg[7:0];
         3'd5:    cmd_byte = {crc_byte, 1'b1};
         default: cmd_byte = FILL_BYTE;
      endcase
   end

   // Sequencer next state and byte-engine input mux.
   always_comb begin
      seq_nxt   = seq_state;
      eng_start = 1'b0;
      eng_cs    = cs_req;
      eng_data  = tx_data;
      case (seq_state)
         SEQ_IDLE: begin
            if (cmd_start && !busy) seq_nxt = SEQ_SEND;
            eng_start = tx_valid & tx_ready;
         end
         SEQ_SEND: begin
            eng_cs   = 1'b1;
            eng_data = cmd_byte;
            if (byte_idx != 3'(CMD_BYTES)) eng_start = eng_idle;
            else if (rx_valid)             seq_nxt   = SEQ_POLL;
         end
         SEQ_POLL: begin
            eng_cs   = 1'b1;
            eng_data = FILL_BYTE;
            if (r1_hit || (rx_valid && poll_cnt == PW'(NCR_MAX))) seq_nxt = SEQ_FIN;
            else eng_start = eng_idle;
         end
         SEQ_FIN: begin
            eng_cs  = 1'b1;
            seq_nxt = SEQ_IDLE;
         end
         default: seq_nxt = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk_spi) begin
      if (reset) begin
         seq_state   <= SEQ_IDLE;
         byte_idx    <= '0;
         poll_cnt    <= '0;
         lat_idx     <= '0;
         lat_arg     <= '0;
         cmd_done    <= 1'b0;
         cmd_r1      <= FILL_BYTE;
         cmd_timeout <= 1'b0;
`ifdef SD_SPI_CRC7_EN
         crc_acc     <= '0;
`else
         lat_crc     <= '0;
`endif
      end else begin
         seq_state <= seq_nxt;
         cmd_done  <= (seq_nxt == SEQ_FIN);
         if (seq_state == SEQ_IDLE && seq_nxt == SEQ_SEND) begin
            lat_idx     <= cmd_index;
            lat_arg     <= cmd_arg;
            byte_idx    <= '0;
            poll_cnt    <= '0;
            cmd_timeout <= 1'b0;
`ifdef SD_SPI_CRC7_EN
            crc_acc     <= '0;
`else
            lat_crc     <= cmd_crc;
`endif
         end
         if (seq_state == SEQ_SEND && eng_start) byte_idx <= byte_idx + 3'd1;
         if (seq_state == SEQ_POLL && eng_start) poll_cnt <= poll_cnt + PW'(1);
         if (seq_state == SEQ_POLL && seq_nxt == SEQ_FIN) begin
            cmd_r1      <= r1_hit ? rx_data : FILL_BYTE;
            cmd_timeout <= ~r1_hit;
         end
`ifdef SD_SPI_CRC7_EN
         // byte_idx 1..5 means one of bytes 0..4 is on the wire.
         if (seq_state == SEQ_SEND && bit_tick && byte_idx != 3'd0 && byte_idx <= 3'd5)
            crc_acc <= crc7_step(crc_acc, mosi);
`endif
      end
   end

   sd_spi_shift #(
      .DIV_W (DIV_W)
   ) u_shift (
      .clk_spi    (clk_spi),
      .reset      (reset),
      .div        (div),
      .start      (eng_start),
      .cs         (eng_cs),
      .data       (eng_data),
      .idle_c     (eng_idle),
`ifdef SD_SPI_CRC7_EN
      .bit_tick_c (bit_tick),
`endif
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .ss         (ss),
      .sck        (sck),
      .mosi       (mosi),
      .miso       (miso)
   );

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master: loopback byte vectors, CMD0/CMD17 against a tiny card model, reset mid-byte.
`timescale 1ns/1ps
module tb_sd_spi_master;

   logic        clk_spi = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  div = 8'd3;
   logic        cs_req = 1'b0;
   logic        tx_valid = 1'b0;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_ready;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        cmd_start = 1'b0;
   logic [5:0]  cmd_index = 6'd0;
   logic [31:0] cmd_arg = 32'd0;
   logic [6:0]  cmd_crc = 7'd0;
   logic        cmd_done;
   logic [7:0]  cmd_r1;
   logic        cmd_timeout;
   logic        busy;
   logic        ss;
   logic        sck;
   logic        mosi;
   logic        miso;
   logic [1:0]  mode = 2'd0;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk_spi = ~clk_spi;

   sd_spi_master #(.DIV_W(8), .NCR_MAX(8)) dut (
      .clk_spi(clk_spi), .reset(reset), .div(div), .cs_req(cs_req),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .cmd_start(cmd_start),
      .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc),
      .cmd_done(cmd_done), .cmd_r1(cmd_r1), .cmd_timeout(cmd_timeout),
      .busy(busy), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso)
   );

   // Card model and wire logger: mode 0 loopback, 1 card (R1=0x01 after one fill byte), 2 miso high.
   logic       sck_q = 1'b0;
   logic [7:0] lsh = 8'h00;
   int         lbit = 0;
   int         rise_cnt = 0;
   int         rise_hi = 0;
   logic [7:0] log_b [0:1023];
   logic       log_s [0:1023];
   int         log_n = 0;
   logic       bnd = 1'b0;
   int         cmd_n = 0;
   logic       pend = 1'b0;
   int         ncr = 0;
   logic [7:0] osh = 8'hFF;

   assign miso = (mode == 2'd0) ? mosi : (mode == 2'd1) ? osh[7] : 1'b1;

   always @(posedge clk_spi) begin
      sck_q <= sck;
      if (sck && !sck_q) begin
         rise_cnt <= rise_cnt + 1;
         if (ss) rise_hi <= rise_hi + 1;
         lsh <= {lsh[6:0], mosi};
         if (lbit == 7) begin
            lbit <= 0;
            if (log_n < 1024) begin
               log_b[log_n] <= {lsh[6:0], mosi};
               log_s[log_n] <= ss;
               log_n <= log_n + 1;
            end
            if (!ss) begin
               bnd <= 1'b1;
               if (cmd_n == 0 && lsh[6:5] == 2'b01) cmd_n <= 1;
               else if (cmd_n > 0 && cmd_n < 5) cmd_n <= cmd_n + 1;
               else if (cmd_n == 5) begin
                  cmd_n <= 0;
                  pend  <= 1'b1;
                  ncr   <= 1;
               end
            end
         end else begin
            lbit <= lbit + 1;
         end
      end
      if (sck_q && !sck && !ss) begin
         if (bnd) begin
            bnd <= 1'b0;
            if (pend && ncr > 0) begin
               ncr <= ncr - 1;
               osh <= 8'hFF;
            end else if (pend) begin
               osh  <= 8'h01;
               pend <= 1'b0;
            end else begin
               osh <= 8'hFF;
            end
         end else begin
            osh <= {osh[6:0], 1'b1};
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Call just after a negedge; returns at the negedge where rx_valid is seen.
   task automatic do_byte(input logic [7:0] d, input logic [7:0] dv, input logic cs,
                          output logic [7:0] rx, output int lat, output int hi_run,
                          output logic ss_bad);
      int run;
      div = dv; cs_req = cs; tx_data = d; tx_valid = 1'b1;
      @(negedge clk_spi);
      tx_valid = 1'b0;
      lat = 1; run = 0; hi_run = 0; ss_bad = 1'b0;
      while (!rx_valid && lat < 2000) begin
         if (ss !== ~cs) ss_bad = 1'b1;
         if (sck) run++;
         else begin
            if (run > 0) hi_run = run;
            run = 0;
         end
         @(negedge clk_spi);
         lat++;
      end
      rx = rx_data;
   endtask

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                          output logic done_ok);
      cmd_index = idx; cmd_arg = arg; cmd_crc = crc; cmd_start = 1'b1;
      @(negedge clk_spi);
      cmd_start = 1'b0;
      check("busy_after_cmd_start", 32'(busy), 32'd1);
      check("tx_ready_during_cmd", 32'(tx_ready), 32'd0);
      done_ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (cmd_done) begin
            done_ok = 1'b1;
            break;
         end
         @(negedge clk_spi);
      end
   endtask

   typedef struct {
      logic [7:0] dv;
      logic       cs;
      logic [7:0] d;
      logic [7:0] exp_rx;
      int         exp_hi;
      int         exp_lat;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rx;
      int         lat;
      int         hi;
      logic       ss_bad;
      logic       ok;
      int         base;
      logic [7:0] cmd0_exp [6];

      vecs[0] = '{8'd3, 1'b1, 8'hA5, 8'hA5, 4, 66};
      vecs[1] = '{8'd0, 1'b1, 8'h3C, 8'h3C, 2, 34};
      vecs[2] = '{8'd1, 1'b0, 8'hC3, 8'hC3, 2, 34};
      vecs[3] = '{8'd2, 1'b1, 8'h00, 8'h00, 3, 50};
      vecs[4] = '{8'd5, 1'b1, 8'hFF, 8'hFF, 6, 98};
      cmd0_exp = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};

      repeat (3) @(negedge clk_spi);
      check("rst_ss", 32'(ss), 32'd1);
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd1);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_cmd_done", 32'(cmd_done), 32'd0);
      check("rst_cmd_r1", 32'(cmd_r1), 32'hFF);
      check("rst_cmd_timeout", 32'(cmd_timeout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      mode = 2'd0;
      for (int i = 0; i < 5; i++) begin
         do_byte(vecs[i].d, vecs[i].dv, vecs[i].cs, rx, lat, hi, ss_bad);
         check($sformatf("vec%0d_rx_data", i), 32'(rx), 32'(vecs[i].exp_rx));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_sck_high", i), 32'(hi), 32'(vecs[i].exp_hi));
         check($sformatf("vec%0d_ss_stable", i), 32'(ss_bad), 32'd0);
      end

      // Dummy clocks with ss high, then CMD0 against the card model.
      mode = 2'd1;
      base = rise_hi;
      for (int i = 0; i < 10; i++) do_byte(8'hFF, 8'd1, 1'b0, rx, lat, hi, ss_bad);
      check("dummy_rises_ss_high", 32'(rise_hi - base), 32'd80);
      base = log_n;
      run_cmd(6'd0, 32'd0, 7'h4A, ok);
      check("cmd0_done", 32'(ok), 32'd1);
      check("cmd0_r1", 32'(cmd_r1), 32'h01);
      check("cmd0_timeout", 32'(cmd_timeout), 32'd0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("cmd0_byte%0d", i), 32'(log_b[base + i]), 32'(cmd0_exp[i]));
         check($sformatf("cmd0_ss_byte%0d", i), 32'(log_s[base + i]), 32'd0);
      end
      @(negedge clk_spi);
      check("ss_held_after_cmd", 32'(ss), 32'd0);
      check("cmd_done_pulse", 32'(cmd_done), 32'd0);

`ifdef SD_SPI_CRC7_EN
      base = log_n;
      run_cmd(6'd8, 32'h0000_01AA, 7'd0, ok);
      check("cmd8_done", 32'(ok), 32'd1);
      check("cmd8_crc_byte", 32'(log_b[base + 5]), 32'h87);
      check("cmd8_r1", 32'(cmd_r1), 32'h01);
      @(negedge clk_spi);
`endif

      // miso stuck high: 6 command bytes plus 8 polls, then timeout.
      mode = 2'd2;
      div = 8'd1;
      base = log_n;
      run_cmd(6'd17, 32'd0, 7'h00, ok);
      check("cmd17_done", 32'(ok), 32'd1);
      check("cmd17_r1", 32'(cmd_r1), 32'hFF);
      check("cmd17_timeout", 32'(cmd_timeout), 32'd1);
      check("cmd17_bytes", 32'(log_n - base), 32'd14);
      @(negedge clk_spi);

      // Reset in the middle of bit 4.
      mode = 2'd0;
      div = 8'd3; cs_req = 1'b1; tx_data = 8'h5A; tx_valid = 1'b1;
      @(negedge clk_spi);
      tx_valid = 1'b0;
      base = rise_cnt;
      for (int i = 0; i < 500 && rise_cnt < base + 5; i++) @(negedge clk_spi);
      check("reach_bit4", 32'(rise_cnt - base), 32'd5);
      @(negedge clk_spi);
      reset = 1'b1;
      @(negedge clk_spi);
      check("midrst_ss", 32'(ss), 32'd1);
      check("midrst_sck", 32'(sck), 32'd0);
      check("midrst_mosi", 32'(mosi), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_rx_valid", 32'(rx_valid), 32'd0);
      @(negedge clk_spi);
      check("midrst_rx_valid_hold", 32'(rx_valid), 32'd0);
      reset = 1'b0;
      do_byte(8'h3C, 8'd3, 1'b1, rx, lat, hi, ss_bad);
      check("postrst_latency", 32'(lat), 32'd66);
      check("postrst_rx_data", 32'(rx), 32'h3C);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
